// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: H/V counters advanced by a pixel clock-enable,
// registered blanking/sync/DE/RGB outputs and per-frame adjustable sync position.
module video_timing_gen #(
    parameter int   H_TOTAL      = 456,
    parameter int   H_ACTIVE     = 336,
    parameter int   H_SYNC_START = 360,
    parameter int   H_SYNC_WIDTH = 24,
    parameter int   V_TOTAL      = 262,
    parameter int   V_ACTIVE     = 240,
    parameter int   V_SYNC_START = 244,
    parameter int   V_SYNC_WIDTH = 3,
    parameter int   HOFFS_W      = 5,
    parameter int   VOFFS_W      = 3,
    parameter int   RGB_W        = 8,
    parameter logic SYNC_POL     = 1'b0,
    localparam int  CNT_H        = $clog2(H_TOTAL),
    localparam int  CNT_V        = $clog2(V_TOTAL)
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic                      ce_pix,
    input  logic signed [HOFFS_W-1:0] hoffs,
    input  logic signed [VOFFS_W-1:0] voffs,
    input  logic        [RGB_W-1:0]   rgb_in,
    output logic        [CNT_H-1:0]   hpos,
    output logic        [CNT_V-1:0]   vpos,
    output logic                      hblank,
    output logic                      vblank,
    output logic                      de,
    output logic                      hsync,
    output logic                      vsync,
    output logic        [RGB_W-1:0]   rgb_out,
    output logic                      line_start,
    output logic                      frame_start
);
    localparam int HW = CNT_H + 2;
    localparam int VW = CNT_V + 2;
    localparam logic [CNT_H-1:0] H_LAST = CNT_H'(H_TOTAL - 1);
    localparam logic [CNT_V-1:0] V_LAST = CNT_V'(V_TOTAL - 1);
    localparam logic [CNT_H-1:0] H_ACT  = CNT_H'(H_ACTIVE);
    localparam logic [CNT_V-1:0] V_ACT  = CNT_V'(V_ACTIVE);
    localparam logic signed [HW-1:0] H_TOT_S = HW'(H_TOTAL);
    localparam logic signed [HW-1:0] H_SS_S  = HW'(H_SYNC_START);
    localparam logic signed [HW-1:0] H_SW_S  = HW'(H_SYNC_WIDTH);
    localparam logic signed [VW-1:0] V_TOT_S = VW'(V_TOTAL);
    localparam logic signed [VW-1:0] V_SS_S  = VW'(V_SYNC_START);
    localparam logic signed [VW-1:0] V_SW_S  = VW'(V_SYNC_WIDTH);

    logic        [CNT_H-1:0]   hcnt_q, hcnt_d;
    logic        [CNT_V-1:0]   vcnt_q, vcnt_d;
    logic signed [HOFFS_W-1:0] hoffs_q;
    logic signed [VOFFS_W-1:0] voffs_q;
    logic                      hblank_q, vblank_q, de_q, hsync_q, vsync_q;
    logic        [RGB_W-1:0]   rgb_q;
    logic                      line_start_q, frame_start_q;

    logic                      h_last_s, v_last_s, hblank_s, vblank_s, de_s;
    logic signed [HW-1:0]      hoff_x_s, hs_raw_s, hs_b_s, hs_e_raw_s, hs_e_s, hcnt_x_s;
    logic signed [VW-1:0]      voff_x_s, vs_raw_s, vs_b_s, vs_e_raw_s, vs_e_s, vcnt_x_s;
    logic                      hs_in_s, vs_in_s;

    // Counter next-state and active-area decode
    always_comb begin
        h_last_s = (hcnt_q == H_LAST);
        v_last_s = (vcnt_q == V_LAST);
        if (h_last_s) begin
            hcnt_d = {CNT_H{1'b0}};
            vcnt_d = v_last_s ? {CNT_V{1'b0}} : vcnt_q + CNT_V'(1);
        end else begin
            hcnt_d = hcnt_q + CNT_H'(1);
            vcnt_d = vcnt_q;
        end
        hblank_s = (hcnt_q >= H_ACT);
        vblank_s = (vcnt_q >= V_ACT);
        de_s     = ~(hblank_s | vblank_s);
    end

    // Horizontal sync window; offset range keeps one TOTAL correction sufficient
    always_comb begin
        hoff_x_s = {{(HW-HOFFS_W){hoffs_q[HOFFS_W-1]}}, hoffs_q};
        hs_raw_s = H_SS_S + (hoff_x_s <<< 1);
        if (hs_raw_s[HW-1]) begin
            hs_b_s = hs_raw_s + H_TOT_S;
        end else if (hs_raw_s >= H_TOT_S) begin
            hs_b_s = hs_raw_s - H_TOT_S;
        end else begin
            hs_b_s = hs_raw_s;
        end
        hs_e_raw_s = hs_b_s + H_SW_S;
        if (hs_e_raw_s >= H_TOT_S) begin
            hs_e_s = hs_e_raw_s - H_TOT_S;
        end else begin
            hs_e_s = hs_e_raw_s;
        end
        hcnt_x_s = {2'b00, hcnt_q};
        if (hs_b_s <= hs_e_s) begin
            hs_in_s = (hcnt_x_s >= hs_b_s) && (hcnt_x_s < hs_e_s);
        end else begin
            hs_in_s = (hcnt_x_s >= hs_b_s) || (hcnt_x_s < hs_e_s);
        end
    end

    // Vertical sync window, same arithmetic on line numbers
    always_comb begin
        voff_x_s = {{(VW-VOFFS_W){voffs_q[VOFFS_W-1]}}, voffs_q};
        vs_raw_s = V_SS_S + (voff_x_s <<< 1);
        if (vs_raw_s[VW-1]) begin
            vs_b_s = vs_raw_s + V_TOT_S;
        end else if (vs_raw_s >= V_TOT_S) begin
            vs_b_s = vs_raw_s - V_TOT_S;
        end else begin
            vs_b_s = vs_raw_s;
        end
        vs_e_raw_s = vs_b_s + V_SW_S;
        if (vs_e_raw_s >= V_TOT_S) begin
            vs_e_s = vs_e_raw_s - V_TOT_S;
        end else begin
            vs_e_s = vs_e_raw_s;
        end
        vcnt_x_s = {2'b00, vcnt_q};
        if (vs_b_s <= vs_e_s) begin
            vs_in_s = (vcnt_x_s >= vs_b_s) && (vcnt_x_s < vs_e_s);
        end else begin
            vs_in_s = (vcnt_x_s >= vs_b_s) || (vcnt_x_s < vs_e_s);
        end
    end

    // Counters, frame-boundary offset latch and registered pixel outputs
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q        <= {CNT_H{1'b0}};
            vcnt_q        <= {CNT_V{1'b0}};
            hoffs_q       <= {HOFFS_W{1'b0}};
            voffs_q       <= {VOFFS_W{1'b0}};
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            de_q          <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            rgb_q         <= {RGB_W{1'b0}};
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            if (ce_pix) begin
                hcnt_q   <= hcnt_d;
                vcnt_q   <= vcnt_d;
                hblank_q <= hblank_s;
                vblank_q <= vblank_s;
                de_q     <= de_s;
                rgb_q    <= de_s ? rgb_in : {RGB_W{1'b0}};
                hsync_q  <= hs_in_s ? SYNC_POL : ~SYNC_POL;
                line_start_q  <= (hcnt_q == {CNT_H{1'b0}});
                frame_start_q <= (hcnt_q == {CNT_H{1'b0}}) && (vcnt_q == {CNT_V{1'b0}});
                // Vertical sync moves only on line boundaries
                if (hcnt_q == {CNT_H{1'b0}}) begin
                    vsync_q <= vs_in_s ? SYNC_POL : ~SYNC_POL;
                end
                // New offsets take effect with the next frame only
                if (h_last_s && v_last_s) begin
                    hoffs_q <= hoffs;
                    voffs_q <= voffs;
                end
            end
        end
    end

    assign hpos        = hcnt_q;
    assign vpos        = vcnt_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb_out     = rgb_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: default, wrapped-hsync and short-frame instances
// share stimulus; a behavioural raster model predicts every output word per clk_sys.
module tb_video_timing_gen;
    logic              clk = 1'b0;
    logic              reset_n;
    logic              ce_pix;
    logic signed [4:0] hoffs;
    logic signed [2:0] voffs;
    logic        [7:0] rgb_in;

    logic [8:0] hpos_d, vpos_d, hpos_w, vpos_w, hpos_s;
    logic [4:0] vpos_s;
    logic       hb_d, vb_d, de_d, hs_d, vs_d, ls_d, fs_d;
    logic       hb_w, vb_w, de_w, hs_w, vs_w, ls_w, fs_w;
    logic       hb_s, vb_s, de_s, hs_s, vs_s, ls_s, fs_s;
    logic [7:0] rgb_d, rgb_w, rgb_s;

    localparam logic [14:0] RST_V = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

    typedef struct {
        logic [14:0] e_def;
        logic [14:0] e_wrap;
        logic [14:0] e_sm;
    } exp_t;
    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;
    int mh, mv_big, mv_sm, lh_big, lv_big, lh_sm, lv_sm;
    logic [14:0] last_def, last_wrap, last_sm;

    always #5 clk = ~clk;

    video_timing_gen u_def (
        .clk_sys(clk), .reset_n(reset_n), .ce_pix(ce_pix), .hoffs(hoffs), .voffs(voffs),
        .rgb_in(rgb_in), .hpos(hpos_d), .vpos(vpos_d), .hblank(hb_d), .vblank(vb_d), .de(de_d),
        .hsync(hs_d), .vsync(vs_d), .rgb_out(rgb_d), .line_start(ls_d), .frame_start(fs_d)
    );

    video_timing_gen #(.H_SYNC_START(440)) u_wrap (
        .clk_sys(clk), .reset_n(reset_n), .ce_pix(ce_pix), .hoffs(hoffs), .voffs(voffs),
        .rgb_in(rgb_in), .hpos(hpos_w), .vpos(vpos_w), .hblank(hb_w), .vblank(vb_w), .de(de_w),
        .hsync(hs_w), .vsync(vs_w), .rgb_out(rgb_w), .line_start(ls_w), .frame_start(fs_w)
    );

    // Short frame (20 lines) so offset latching across frames fits in a short run
    video_timing_gen #(.V_TOTAL(20), .V_ACTIVE(12), .V_SYNC_START(14)) u_sm (
        .clk_sys(clk), .reset_n(reset_n), .ce_pix(ce_pix), .hoffs(hoffs), .voffs(voffs),
        .rgb_in(rgb_in), .hpos(hpos_s), .vpos(vpos_s), .hblank(hb_s), .vblank(vb_s), .de(de_s),
        .hsync(hs_s), .vsync(vs_s), .rgb_out(rgb_s), .line_start(ls_s), .frame_start(fs_s)
    );

    // Expected output word {hblank,vblank,de,hsync,vsync,line_start,frame_start,rgb}
    function automatic logic [14:0] model_px(input int h, input int v, input int hss, input int hoff,
                                             input int vss, input int vact, input int vtot,
                                             input int voff, input logic [7:0] rgb);
        int   hb, vb;
        logic hbk, vbk, den, hin, vin;
        hb  = ((hss + 2 * hoff) % 456 + 456) % 456;
        hin = ((h - hb + 456) % 456) < 24;
        vb  = ((vss + 2 * voff) % vtot + vtot) % vtot;
        vin = ((v - vb + vtot) % vtot) < 3;
        hbk = (h >= 336);
        vbk = (v >= vact);
        den = !(hbk || vbk);
        return {hbk, vbk, den, ~hin, ~vin, (h == 0), (h == 0 && v == 0), den ? rgb : 8'h00};
    endfunction

    task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s h=%0d v=%0d observed=%h expected=%h", tag, mh, mv_big, obs, exp);
        end
    endtask

    task automatic model_reset();
        mh = 0; mv_big = 0; mv_sm = 0;
        lh_big = 0; lv_big = 0; lh_sm = 0; lv_sm = 0;
        last_def = RST_V; last_wrap = RST_V; last_sm = RST_V;
    endtask

    task automatic check_outputs(input exp_t e, input string sfx);
        chk({"def", sfx},  {hb_d, vb_d, de_d, hs_d, vs_d, ls_d, fs_d, rgb_d}, e.e_def);
        chk({"wrap", sfx}, {hb_w, vb_w, de_w, hs_w, vs_w, ls_w, fs_w, rgb_w}, e.e_wrap);
        chk({"sm", sfx},   {hb_s, vb_s, de_s, hs_s, vs_s, ls_s, fs_s, rgb_s}, e.e_sm);
        chk({"hpos", sfx}, 15'(hpos_d), 15'(mh));
        chk({"vpos", sfx}, 15'(vpos_d), 15'(mv_big));
        chk({"vpos_sm", sfx}, 15'(vpos_s), 15'(mv_sm));
    endtask

    // One clk_sys: drive, push prediction, advance model, then compare after the edge
    task automatic cyc(input logic ce, input logic [7:0] rgb);
        exp_t e;
        @(negedge clk);
        ce_pix = ce;
        rgb_in = rgb;
        if (ce) begin
            last_def  = model_px(mh, mv_big, 360, lh_big, 244, 240, 262, lv_big, rgb);
            last_wrap = model_px(mh, mv_big, 440, lh_big, 244, 240, 262, lv_big, rgb);
            last_sm   = model_px(mh, mv_sm,  360, lh_sm,  14,  12,  20,  lv_sm,  rgb);
            if (mh == 455 && mv_big == 261) begin lh_big = hoffs; lv_big = voffs; end
            if (mh == 455 && mv_sm == 19)   begin lh_sm  = hoffs; lv_sm  = voffs; end
            if (mh == 455) begin
                mh     = 0;
                mv_big = (mv_big == 261) ? 0 : mv_big + 1;
                mv_sm  = (mv_sm == 19) ? 0 : mv_sm + 1;
            end else begin
                mh = mh + 1;
            end
        end else begin
            last_def[9:8] = 2'b00; last_wrap[9:8] = 2'b00; last_sm[9:8] = 2'b00;
        end
        e.e_def = last_def; e.e_wrap = last_wrap; e.e_sm = last_sm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_outputs(sb_q.pop_front(), "_px");
    endtask

    task automatic run_px(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 8'($urandom_range(1, 255)));
    endtask

    task automatic check_reset(input string sfx);
        exp_t e;
        e.e_def = RST_V; e.e_wrap = RST_V; e.e_sm = RST_V;
        mh = 0; mv_big = 0; mv_sm = 0;
        check_outputs(e, sfx);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; ce_pix = 1'b0; hoffs = 5'sd0; voffs = 3'sd0; rgb_in = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset("_por");
        @(negedge clk);
        reset_n = 1'b1;

        // Frame 0 of u_sm at offset 0; hoffs=5 arrives at line 5 and applies from frame 1
        run_px(5 * 456);
        hoffs = 5'sd5;
        run_px(20 * 456);
        hoffs = 5'sd15;
        run_px(25 * 456 + 200);

        // Async reset at pixel (200,50)
        #2;
        reset_n = 1'b0;
        #1;
        check_reset("_rst_now");
        repeat (3) @(posedge clk);
        #1;
        check_reset("_rst_hold");
        ce_pix = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // Negative offsets apply to the second short frame after reset
        hoffs = -5'sd16;
        voffs = -3'sd4;
        run_px(40 * 456);

        // ce_pix 1-in-4: outputs hold between enables, rgb_in noise ignored
        for (int i = 0; i < 2 * 456; i++) begin
            cyc(1'b1, 8'hA5);
            for (int k = 0; k < 3; k++) cyc(1'b0, 8'h3C);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
